// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and ROM read master. Fetched words land in a small
// prefetch FIFO that is handed to decode through a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       MEM_BYTES = 76,
  parameter int unsigned       DEPTH     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_en,
  input  logic [31:0]       i_imem_data,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [31:0]       o_inst_data,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_fault,
  output logic [ADDR_W-1:0] o_fault_pc,
  output logic              o_done
);

  localparam int unsigned     PtrW    = $clog2(DEPTH);
  localparam int unsigned     CntW    = $clog2(DEPTH + 1);
  localparam int unsigned     ExtW    = ADDR_W + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [ExtW-1:0] MemEnd  = ExtW'(MEM_BYTES);

  typedef enum logic [1:0] {StRun, StEnd, StFault} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_pc;
  logic [31:0]       r_fifo_data [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [ExtW-1:0] w_pc_next_ext;
  logic            w_rd_aligned;
  logic            w_rd_past_end;

  // Full/empty come from the pre-edge count, so a pop never frees a slot for
  // a same-cycle push.
  assign w_full        = (r_count == FullCnt);
  assign w_empty       = (r_count == '0);
  assign o_imem_en     = (r_state == StRun) && !w_full && i_rst_n && !i_redirect_valid;
  assign o_imem_addr   = r_pc;
  assign w_push        = o_imem_en;
  assign o_inst_valid  = !w_empty && (r_state != StFault);
  assign w_pop         = o_inst_valid && i_inst_ready && !i_redirect_valid;
  assign o_inst_data   = r_fifo_data[r_rptr];
  assign o_inst_pc     = r_fifo_pc[r_rptr];
  assign o_fault       = r_fault;
  assign o_fault_pc    = r_fault_pc;
  assign o_done        = (r_state == StEnd) && w_empty;

  // One extra bit so the end-of-program compare cannot wrap.
  assign w_pc_next_ext = {1'b0, r_pc} + ExtW'(4);
  assign w_rd_aligned  = (i_redirect_pc[1:0] == 2'b00);
  assign w_rd_past_end = ({1'b0, i_redirect_pc} >= MemEnd);

  // Fetch control FSM: PC, run/end/fault state and the sticky fault record.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StRun;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (i_redirect_valid) begin
      if (w_rd_aligned) begin
        r_pc    <= i_redirect_pc;
        r_fault <= 1'b0;
        r_state <= w_rd_past_end ? StEnd : StRun;
      end else begin
        r_state    <= StFault;
        r_fault    <= 1'b1;
        r_fault_pc <= i_redirect_pc;
      end
    end else if (w_push) begin
      r_pc <= w_pc_next_ext[ADDR_W-1:0];
      if (w_pc_next_ext >= MemEnd) begin
        r_state <= StEnd;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect flushes and discards any pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: capture the ROM word with the PC it was fetched from.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= i_imem_data;
      r_fifo_pc[r_wptr]   <= r_pc;
    end
  end

endmodule
